// File: rtl/seq_detect_multi_sync.sv
// Multi-channel pattern detector: each asynchronous input is synchronized into clk_sys
// and matched against a programmable pattern, with per-channel pulse, sticky flag and counter.
module seq_detect_multi_sync #(
    parameter int          N_CH        = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int          PAT_W       = 4,
    parameter logic [15:0] PAT_RESET   = 16'h000B,
    parameter int          CNT_W       = 8
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [N_CH-1:0]       async_in,
    input  logic [PAT_W-1:0]      pattern,
    input  logic                  cfg_load,
    input  logic                  overlap_en,
    input  logic                  enable,
    input  logic                  clear,
    output logic [N_CH-1:0]       detected,
    output logic [N_CH-1:0]       det_sticky,
    output logic                  any_detected,
    output logic [N_CH*CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0]      pat_q
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [SYNC_STAGES-1:0] sync_ff  [N_CH];
    logic [PAT_W-1:0]       hist_q   [N_CH];
    logic [FILL_W-1:0]      fill_q   [N_CH];
    logic [CNT_W-1:0]       cnt_q    [N_CH];
    logic [PAT_W-1:0]       nxt_hist [N_CH];
    logic [FILL_W-1:0]      nxt_fill [N_CH];
    logic [N_CH-1:0]        det_nxt;

    // NOTE: every variable gets a default at the top of always_comb, so no path leaves it unassigned (no latch).
    always_comb begin
        det_nxt   = '0;
        match_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            nxt_hist[i] = {hist_q[i][PAT_W-2:0], sync_ff[i][SYNC_STAGES-1]};
            nxt_fill[i] = (fill_q[i] == FILL_FULL) ? FILL_FULL : fill_q[i] + FILL_W'(1);
            // A load or clear in the same cycle suppresses the match entirely.
            det_nxt[i]  = enable && !cfg_load && !clear &&
                          (nxt_fill[i] == FILL_FULL) && (nxt_hist[i] == pat_q);
            match_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    // Synchronizer chains run freely, independent of every control input.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            // NOTE: these arrays are small per-channel register banks, not RAM, so each entry is reset.
            for (int i = 0; i < N_CH; i++) sync_ff[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            for (int i = 0; i < N_CH; i++)
                sync_ff[i] <= {sync_ff[i][SYNC_STAGES-2:0], async_in[i]};
        end
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                hist_q[i] <= '0;
                fill_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            det_sticky   <= '0;
            detected     <= '0;
            any_detected <= 1'b0;
            pat_q        <= PAT_RESET[PAT_W-1:0];
        end else begin
            detected     <= det_nxt;
            any_detected <= |det_nxt;
            if (cfg_load) pat_q <= pattern;
            for (int i = 0; i < N_CH; i++) begin
                if (clear) begin
                    hist_q[i]     <= '0;
                    fill_q[i]     <= '0;
                    cnt_q[i]      <= '0;
                    det_sticky[i] <= 1'b0;
                end else if (enable) begin
                    hist_q[i] <= nxt_hist[i];
                    // Non-overlapping mode restarts the fill so the next match needs PAT_W fresh bits.
                    fill_q[i] <= (cfg_load || (det_nxt[i] && !overlap_en)) ? '0 : nxt_fill[i];
                    if (det_nxt[i]) begin
                        det_sticky[i] <= 1'b1;
                        if (cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end else if (cfg_load) begin
                    fill_q[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_multi_sync.sv
// Self-checking bench for seq_detect_multi_sync: directed scenarios plus random traffic,
// compared cycle by cycle against a bit-list reference model through a scoreboard queue.
module tb_seq_detect_multi_sync;

    localparam int N_CH  = 4;
    localparam int SS    = 2;
    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
    localparam logic [PAT_W-1:0] PAT_RST = 4'b1011;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic                  clk_sys = 1'b0;
    logic                  reset;
    logic [N_CH-1:0]       async_in;
    logic [PAT_W-1:0]      pattern;
    logic                  cfg_load, overlap_en, enable, clear;
    logic [N_CH-1:0]       detected, det_sticky;
    logic                  any_detected;
    logic [N_CH*CNT_W-1:0] match_cnt;
    logic [PAT_W-1:0]      pat_q;

    seq_detect_multi_sync #(
        .N_CH(N_CH), .SYNC_STAGES(SS), .PAT_W(PAT_W),
        .PAT_RESET(16'h000B), .CNT_W(CNT_W)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .async_in(async_in), .pattern(pattern),
        .cfg_load(cfg_load), .overlap_en(overlap_en), .enable(enable), .clear(clear),
        .detected(detected), .det_sticky(det_sticky), .any_detected(any_detected),
        .match_cnt(match_cnt), .pat_q(pat_q)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [N_CH-1:0]       det;
        logic [N_CH-1:0]       sticky;
        logic [N_CH*CNT_W-1:0] cnt;
        logic [PAT_W-1:0]      pat;
        logic                  any;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   pulses[N_CH];

    // Reference model: the received bit window per channel, bits counted since the last restart.
    logic [N_CH-1:0]  m_dl [SS];
    bit               m_win [N_CH][PAT_W];
    int               m_seen [N_CH];
    bit               m_sticky [N_CH];
    int               m_cnt [N_CH];
    logic [PAT_W-1:0] m_pat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SS; k++) m_dl[k] = '0;
        for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < PAT_W; k++) m_win[c][k] = 1'b0;
            m_seen[c] = 0; m_sticky[c] = 1'b0; m_cnt[c] = 0;
        end
        m_pat = PAT_RST;
    endtask

    task automatic step();
        exp_t            e;
        logic [N_CH-1:0] sq;
        bit              matched;
        e = '0;
        if (!reset) begin
            model_reset();
        end else begin
            sq = m_dl[SS-1];
            for (int c = 0; c < N_CH; c++) begin
                if (clear) begin
                    for (int k = 0; k < PAT_W; k++) m_win[c][k] = 1'b0;
                    m_seen[c] = 0; m_sticky[c] = 1'b0; m_cnt[c] = 0;
                end else if (enable) begin
                    for (int k = 0; k < PAT_W - 1; k++) m_win[c][k] = m_win[c][k+1];
                    m_win[c][PAT_W-1] = sq[c];
                    if (m_seen[c] < PAT_W) m_seen[c]++;
                    matched = 1'b1;
                    for (int k = 0; k < PAT_W; k++)
                        if (m_win[c][k] != m_pat[PAT_W-1-k]) matched = 1'b0;
                    if (!cfg_load && m_seen[c] == PAT_W && matched) begin
                        e.det[c] = 1'b1;
                        m_sticky[c] = 1'b1;
                        if (m_cnt[c] < CNT_TOP) m_cnt[c]++;
                        if (!overlap_en) m_seen[c] = 0;
                    end
                    if (cfg_load) m_seen[c] = 0;
                end else if (cfg_load) begin
                    m_seen[c] = 0;
                end
            end
            if (cfg_load) m_pat = pattern;
            for (int k = SS - 1; k > 0; k--) m_dl[k] = m_dl[k-1];
            m_dl[0] = async_in;
        end
        for (int c = 0; c < N_CH; c++) begin
            e.sticky[c] = m_sticky[c];
            e.cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        end
        e.pat = m_pat;
        e.any = |e.det;
        exp_q.push_back(e);
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    // Monitor: outputs are valid every cycle, so one expectation is consumed per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_sys);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("detected",     64'(detected),     64'(e.det));
                check("det_sticky",   64'(det_sticky),   64'(e.sticky));
                check("match_cnt",    64'(match_cnt),    64'(e.cnt));
                check("pat_q",        64'(pat_q),        64'(e.pat));
                check("any_detected", 64'(any_detected), 64'(e.any));
                for (int c = 0; c < N_CH; c++) if (detected[c] === 1'b1) pulses[c]++;
            end
        end
    end

    task automatic zero_pulses();
        for (int c = 0; c < N_CH; c++) pulses[c] = 0;
    endtask

    task automatic flush();
        async_in = '0;
        repeat (SS + 2) step();
    endtask

    task automatic send(input int ch, input logic [15:0] bits, input int n);
        for (int j = n - 1; j >= 0; j--) begin
            async_in = '0;
            async_in[ch] = bits[j];
            step();
        end
        flush();
    endtask

    task automatic do_clear();
        clear = 1'b1; step(); clear = 1'b0;
        zero_pulses();
    endtask

    task automatic load_pattern(input logic [PAT_W-1:0] p);
        pattern = p; cfg_load = 1'b1; step(); cfg_load = 1'b0;
    endtask

    initial begin
        logic [11:0] en_seq;
        logic [11:0] bit_seq;
        reset = 1'b0; async_in = '0; pattern = '0; cfg_load = 1'b0;
        overlap_en = 1'b1; enable = 1'b1; clear = 1'b0;
        zero_pulses();
        model_reset();
        @(negedge clk_sys);
        repeat (3) step();
        reset = 1'b1;
        repeat (4) step();

        // Default pattern on channel 0, other channels idle.
        zero_pulses();
        send(0, 16'b1011, 4);
        check("ch0_pulses", 64'(pulses[0]), 64'd1);
        check("ch1to3_pulses", 64'(pulses[1] + pulses[2] + pulses[3]), 64'd0);

        // Overlapping versus non-overlapping on channel 1.
        do_clear();
        send(1, 16'b1011011, 7);
        check("overlap_pulses", 64'(pulses[1]), 64'd2);
        do_clear();
        overlap_en = 1'b0;
        send(1, 16'b1011011, 7);
        check("nonoverlap_pulses", 64'(pulses[1]), 64'd1);

        // All-ones pattern held high on channel 2.
        do_clear();
        overlap_en = 1'b1;
        load_pattern(4'b1111);
        send(2, 16'h03FF, 10);
        check("ones_overlap_pulses", 64'(pulses[2]), 64'd7);
        do_clear();
        overlap_en = 1'b0;
        send(2, 16'h03FF, 10);
        check("ones_nonoverlap_pulses", 64'(pulses[2]), 64'd2);

        // Counter saturation, then a clear landing on a hit cycle.
        overlap_en = 1'b1;
        load_pattern(4'b1011);
        do_clear();
        repeat (5) send(3, 16'b1011, 4);
        check("sat_pulses", 64'(pulses[3]), 64'd5);
        check("sat_cnt", 64'(match_cnt[3*CNT_W +: CNT_W]), 64'(CNT_TOP));
        for (int j = 3; j >= 0; j--) begin
            async_in = '0; async_in[3] = PAT_RST[j]; step();
        end
        async_in = '0;
        step();
        clear = 1'b1; step(); clear = 1'b0;
        flush();
        check("clear_hit_pulses", 64'(pulses[3]), 64'd5);
        check("clear_cnt", 64'(match_cnt[3*CNT_W +: CNT_W]), 64'd0);
        check("clear_sticky", 64'(det_sticky[3]), 64'd0);

        // Disable after 1,0 reaches the matcher; bits arriving while disabled are ignored.
        zero_pulses();
        bit_seq = 12'b1011_1111_0000;
        en_seq  = 12'b1111_0000_1111;
        for (int j = 11; j >= 0; j--) begin
            async_in = '0; async_in[0] = bit_seq[j]; enable = en_seq[j]; step();
        end
        enable = 1'b1;
        flush();
        check("enable_hold_pulses", 64'(pulses[0]), 64'd1);

        // Reset mid-pattern, then mid-pulse; a full pattern afterwards still matches.
        load_pattern(4'b0110);
        async_in = 4'b0001; step();
        async_in = 4'b0000; step();
        reset = 1'b0; #1;
        check("rst_mid_pat", 64'(pat_q), 64'(PAT_RST));
        model_reset();
        step();
        reset = 1'b1;
        for (int j = 3; j >= 0; j--) begin
            async_in = '0; async_in[2] = PAT_RST[j]; step();
        end
        async_in = '0;
        step(); step();
        check("pulse_before_rst", 64'(detected), 64'b0100);
        reset = 1'b0; #1;
        check("rst_detected", 64'(detected), 64'd0);
        check("rst_any", 64'(any_detected), 64'd0);
        check("rst_sticky", 64'(det_sticky), 64'd0);
        check("rst_cnt", 64'(match_cnt), 64'd0);
        model_reset();
        step(); step();
        reset = 1'b1;
        zero_pulses();
        send(2, 16'b1011, 4);
        check("post_rst_pulses", 64'(pulses[2]), 64'd1);

        // Random traffic with all controls toggling.
        for (int n = 0; n < 600; n++) begin
            async_in   = N_CH'($urandom);
            overlap_en = 1'($urandom);
            enable     = ($urandom_range(0, 9) != 0);
            clear      = ($urandom_range(0, 39) == 0);
            cfg_load   = ($urandom_range(0, 24) == 0);
            pattern    = ($urandom_range(0, 1) == 0) ? 4'b1111 : PAT_W'($urandom);
            step();
        end
        clear = 1'b0; cfg_load = 1'b0; enable = 1'b1;
        flush();

        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
